multicycle_control_fsm: RTL and testbench

//  Main control FSM of the multicycle RV32I core; sits directly upstream of ALUdecoder/ALU.

---
 rtl/control_pkg.sv | 54 +++++
 rtl/control_output_decoder.sv | 73 +++++++
 rtl/multicycle_control_fsm.sv | 101 ++++++++++
 tb/tb_multicycle_control_fsm.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/control_pkg.sv
// Shared encodings for the multicycle RV32I control path: states, opcodes, mux selects, control bundle.
package control_pkg;

   typedef enum logic [3:0] {
      S_FETCH      = 4'd0,
      S_DECODE     = 4'd1,
      S_MEMADR     = 4'd2,
      S_MEMREAD    = 4'd3,
      S_MEMWB      = 4'd4,
      S_MEMWRITE   = 4'd5,
      S_EXECUTER   = 4'd6,
      S_EXECUTEI   = 4'd7,
      S_ALUWB      = 4'd8,
      S_BRANCHIFEQ = 4'd9,
      S_JAL        = 4'd10
   } state_t;

   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_RTYPE  = 7'b0110011;
   localparam logic [6:0] OP_ITYPE  = 7'b0010011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;

   localparam logic [1:0] ALU_OP_ADD   = 2'b00;
   localparam logic [1:0] ALU_OP_SUB   = 2'b01;
   localparam logic [1:0] ALU_OP_FUNCT = 2'b10;

   localparam logic [1:0] SRC_A_PC    = 2'b00;
   localparam logic [1:0] SRC_A_OLDPC = 2'b01;
   localparam logic [1:0] SRC_A_RD1   = 2'b10;

   localparam logic [1:0] SRC_B_RD2  = 2'b00;
   localparam logic [1:0] SRC_B_IMM  = 2'b01;
   localparam logic [1:0] SRC_B_FOUR = 2'b10;

   localparam logic [1:0] RES_ALUOUT = 2'b00;
   localparam logic [1:0] RES_MEM    = 2'b01;
   localparam logic [1:0] RES_ALU    = 2'b10;

   typedef struct packed {
      logic       pc_update;
      logic       branch;
      logic       adr_src;
      logic       mem_write;
      logic       ir_write;
      logic       reg_write;
      logic [1:0] result_src;
      logic [1:0] alu_src_a;
      logic [1:0] alu_src_b;
      logic [1:0] alu_op;
   } ctrl_t;

endpackage

// File: rtl/control_output_decoder.sv
// Combinational Moore decode of the control state into the datapath control bundle.
module control_output_decoder
   import control_pkg::*;
(
   input  state_t state_i,
   output ctrl_t  ctrl_o
);

   always_comb begin
      ctrl_o = '0;
      unique case (state_i)
         S_FETCH: begin
            ctrl_o.ir_write   = 1'b1;
            ctrl_o.pc_update  = 1'b1;
            ctrl_o.alu_src_a  = SRC_A_PC;
            ctrl_o.alu_src_b  = SRC_B_FOUR;
            ctrl_o.alu_op     = ALU_OP_ADD;
            ctrl_o.result_src = RES_ALU;
         end
         // Branch target precompute: old_pc + imm parked in alu_out
         S_DECODE: begin
            ctrl_o.alu_src_a = SRC_A_OLDPC;
            ctrl_o.alu_src_b = SRC_B_IMM;
         end
         S_MEMADR: begin
            ctrl_o.alu_src_a = SRC_A_RD1;
            ctrl_o.alu_src_b = SRC_B_IMM;
         end
         S_MEMREAD: begin
            ctrl_o.adr_src    = 1'b1;
            ctrl_o.result_src = RES_ALUOUT;
         end
         S_MEMWB: begin
            ctrl_o.result_src = RES_MEM;
            ctrl_o.reg_write  = 1'b1;
         end
         S_MEMWRITE: begin
            ctrl_o.adr_src    = 1'b1;
            ctrl_o.mem_write  = 1'b1;
            ctrl_o.result_src = RES_ALUOUT;
         end
         S_EXECUTER: begin
            ctrl_o.alu_src_a = SRC_A_RD1;
            ctrl_o.alu_src_b = SRC_B_RD2;
            ctrl_o.alu_op    = ALU_OP_FUNCT;
         end
         S_EXECUTEI: begin
            ctrl_o.alu_src_a = SRC_A_RD1;
            ctrl_o.alu_src_b = SRC_B_IMM;
            ctrl_o.alu_op    = ALU_OP_FUNCT;
         end
         S_ALUWB: begin
            ctrl_o.result_src = RES_ALUOUT;
            ctrl_o.reg_write  = 1'b1;
         end
         S_BRANCHIFEQ: begin
            ctrl_o.alu_src_a  = SRC_A_RD1;
            ctrl_o.alu_src_b  = SRC_B_RD2;
            ctrl_o.alu_op     = ALU_OP_SUB;
            ctrl_o.result_src = RES_ALUOUT;
            ctrl_o.branch     = 1'b1;
         end
         S_JAL: begin
            ctrl_o.alu_src_a  = SRC_A_OLDPC;
            ctrl_o.alu_src_b  = SRC_B_FOUR;
            ctrl_o.result_src = RES_ALUOUT;
            ctrl_o.pc_update  = 1'b1;
         end
         default: ctrl_o = '0;
      endcase
   end

endmodule

// File: rtl/multicycle_control_fsm.sv
// Main control FSM of the multicycle RV32I core.
// Define CONTROL_MEM_STALL_EN to add mem_ready and hold FETCH/MEMREAD/MEMWRITE until it is sampled high.
module multicycle_control_fsm
   import control_pkg::*;
(
   input  logic       clk,
   input  logic       reset_n,
   input  logic [6:0] opcode,
   input  logic       zero,
`ifdef CONTROL_MEM_STALL_EN
   input  logic       mem_ready,
`endif
   output logic       pc_write,
   output logic       adr_src,
   output logic       mem_write,
   output logic       ir_write,
   output logic       reg_write,
   output logic [1:0] result_src,
   output logic [1:0] alu_src_a,
   output logic [1:0] alu_src_b,
   output logic [1:0] alu_op,
   output logic       branch,
   output logic       illegal,
   output logic [3:0] state
);

   state_t state_q, state_d;
   logic   illegal_q, illegal_d;
   logic   mem_wait_c;
   state_t dec_state_c;
   ctrl_t  ctrl_c;

`ifdef CONTROL_MEM_STALL_EN
   assign mem_wait_c = ~mem_ready;
`else
   assign mem_wait_c = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q   <= S_FETCH;
         illegal_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         illegal_q <= illegal_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      illegal_d = illegal_q;
      unique case (state_q)
         S_FETCH:    if (!mem_wait_c) state_d = S_DECODE;
         S_DECODE: begin
            unique case (opcode)
               OP_LOAD, OP_STORE: state_d = S_MEMADR;
               OP_RTYPE:          state_d = S_EXECUTER;
               OP_ITYPE:          state_d = S_EXECUTEI;
               OP_BRANCH:         state_d = S_BRANCHIFEQ;
               OP_JAL:            state_d = S_JAL;
               default: begin
                  state_d   = S_FETCH;
                  illegal_d = 1'b1;
               end
            endcase
         end
         S_MEMADR:     state_d = (opcode == OP_LOAD) ? S_MEMREAD : S_MEMWRITE;
         S_MEMREAD:    if (!mem_wait_c) state_d = S_MEMWB;
         S_MEMWB:      state_d = S_FETCH;
         S_MEMWRITE:   if (!mem_wait_c) state_d = S_FETCH;
         S_EXECUTER:   state_d = S_ALUWB;
         S_EXECUTEI:   state_d = S_ALUWB;
         S_ALUWB:      state_d = S_FETCH;
         S_BRANCHIFEQ: state_d = S_FETCH;
         S_JAL:        state_d = S_ALUWB;
         default:      state_d = S_FETCH;
      endcase
   end

   // Held in reset: selects show FETCH, all strobes suppressed
   assign dec_state_c = reset_n ? state_q : S_FETCH;

   control_output_decoder u_dec (
      .state_i (dec_state_c),
      .ctrl_o  (ctrl_c)
   );

   assign pc_write   = reset_n & (ctrl_c.pc_update | (ctrl_c.branch & zero));
   assign ir_write   = reset_n & ctrl_c.ir_write;
   assign mem_write  = reset_n & ctrl_c.mem_write;
   assign reg_write  = reset_n & ctrl_c.reg_write;
   assign adr_src    = ctrl_c.adr_src;
   assign result_src = ctrl_c.result_src;
   assign alu_src_a  = ctrl_c.alu_src_a;
   assign alu_src_b  = ctrl_c.alu_src_b;
   assign alu_op     = ctrl_c.alu_op;
   assign branch     = ctrl_c.branch;
   assign illegal    = illegal_q;
   assign state      = 4'(state_q);

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Bench for multicycle_control_fsm: per-instruction expected cycle traces against randomized programs.
module tb_multicycle_control_fsm;
   import control_pkg::*;

   typedef struct packed {
      logic [3:0] st;
      logic       pcw, adr, mw, irw, rw;
      logic [1:0] rs, a, b, op;
      logic       br, ill;
   } vec_t;

   logic       clk = 1'b0;
   logic       reset_n = 1'b0;
   logic [6:0] opcode = 7'b0;
   logic       zero = 1'b0;
`ifdef CONTROL_MEM_STALL_EN
   logic       mem_ready = 1'b1;
`endif
   logic       pc_write, adr_src, mem_write, ir_write, reg_write, branch, illegal;
   logic [1:0] result_src, alu_src_a, alu_src_b, alu_op;
   logic [3:0] state;

   int vectors = 0;
   int errors  = 0;
   logic ill_m = 1'b0;
   vec_t q[$];

   always #5 clk = ~clk;

   multicycle_control_fsm dut (
      .clk(clk), .reset_n(reset_n), .opcode(opcode), .zero(zero),
`ifdef CONTROL_MEM_STALL_EN
      .mem_ready(mem_ready),
`endif
      .pc_write(pc_write), .adr_src(adr_src), .mem_write(mem_write), .ir_write(ir_write),
      .reg_write(reg_write), .result_src(result_src), .alu_src_a(alu_src_a),
      .alu_src_b(alu_src_b), .alu_op(alu_op), .branch(branch), .illegal(illegal), .state(state)
   );

   function automatic vec_t mk(input logic [3:0] st, input logic pcw, adr, mw, irw, rw,
                               input logic [1:0] rs, a, b, op, input logic br);
      vec_t v;
      v = '{st:st, pcw:pcw, adr:adr, mw:mw, irw:irw, rw:rw, rs:rs, a:a, b:b, op:op, br:br, ill:1'b0};
      return v;
   endfunction

   function automatic vec_t observe();
      vec_t v;
      v = '{st:state, pcw:pc_write, adr:adr_src, mw:mem_write, irw:ir_write, rw:reg_write,
            rs:result_src, a:alu_src_a, b:alu_src_b, op:alu_op, br:branch, ill:illegal};
      return v;
   endfunction

   // Instruction-level model: the cycle-by-cycle trace each instruction class must produce
   task automatic build_trace(input logic [6:0] opc, output logic is_illegal);
      vec_t memadr, aluwb;
      memadr = mk(S_MEMADR, 0,0,0,0,0, 2'd0, 2'd2, 2'd1, 2'd0, 0);
      aluwb  = mk(S_ALUWB,  0,0,0,0,1, 2'd0, 2'd0, 2'd0, 2'd0, 0);
      is_illegal = 1'b0;
      q.delete();
      q.push_back(mk(S_FETCH,  1,0,0,1,0, 2'd2, 2'd0, 2'd2, 2'd0, 0));
      q.push_back(mk(S_DECODE, 0,0,0,0,0, 2'd0, 2'd1, 2'd1, 2'd0, 0));
      case (opc)
         7'b0000011: begin
            q.push_back(memadr);
            q.push_back(mk(S_MEMREAD, 0,1,0,0,0, 2'd0, 2'd0, 2'd0, 2'd0, 0));
            q.push_back(mk(S_MEMWB,   0,0,0,0,1, 2'd1, 2'd0, 2'd0, 2'd0, 0));
         end
         7'b0100011: begin
            q.push_back(memadr);
            q.push_back(mk(S_MEMWRITE, 0,1,1,0,0, 2'd0, 2'd0, 2'd0, 2'd0, 0));
         end
         7'b0110011: begin
            q.push_back(mk(S_EXECUTER, 0,0,0,0,0, 2'd0, 2'd2, 2'd0, 2'd2, 0));
            q.push_back(aluwb);
         end
         7'b0010011: begin
            q.push_back(mk(S_EXECUTEI, 0,0,0,0,0, 2'd0, 2'd2, 2'd1, 2'd2, 0));
            q.push_back(aluwb);
         end
         7'b1100011: q.push_back(mk(S_BRANCHIFEQ, 0,0,0,0,0, 2'd0, 2'd2, 2'd0, 2'd1, 1));
         7'b1101111: begin
            q.push_back(mk(S_JAL, 1,0,0,0,0, 2'd0, 2'd1, 2'd2, 2'd0, 0));
            q.push_back(aluwb);
         end
         default: is_illegal = 1'b1;
      endcase
   endtask

   // Called at a negedge with the DUT in FETCH; returns at the negedge of the next FETCH.
   // zmode: 0/1 force zero, 2 random per cycle.
   task automatic run_instr(input logic [6:0] opc, input int zmode, input string name);
      logic is_ill;
      vec_t exp, obs;
      build_trace(opc, is_ill);
      for (int i = 0; i < q.size(); i++) begin
         if (i == 0) opcode = opc;
         zero = (zmode == 2) ? 1'($urandom) : 1'(zmode);
         #1;
         exp = q[i];
         exp.ill = ill_m;
         if (exp.br) exp.pcw = zero;
         obs = observe();
         vectors++;
         if (obs !== exp) begin
            errors++;
            $display("FAIL %s op=%b step %0d: got %h want %h", name, opc, i, obs, exp);
         end
         @(negedge clk);
      end
      if (is_ill) ill_m = 1'b1;
   endtask

   task automatic test_reset();
      vec_t exp, obs;
      reset_n = 1'b0;
      repeat (2) @(negedge clk);
      #1;
      exp = mk(S_FETCH, 0,0,0,0,0, 2'd2, 2'd0, 2'd2, 2'd0, 0);
      obs = observe();
      vectors++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL reset_initial: got %h want %h", obs, exp);
      end
      reset_n = 1'b1;
      ill_m = 1'b0;
      // Walk into EXECUTER, then reset for 3 cycles
      opcode = 7'b0110011;
      @(negedge clk);
      @(negedge clk);
      #1;
      vectors++;
      if (state !== 4'(S_EXECUTER)) begin
         errors++;
         $display("FAIL reset_reach_exec: state %0d want %0d", state, 4'(S_EXECUTER));
      end
      reset_n = 1'b0;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         #1;
         obs = observe();
         vectors++;
         if (obs !== exp) begin
            errors++;
            $display("FAIL reset_mid_instr cycle %0d: got %h want %h", c, obs, exp);
         end
      end
      reset_n = 1'b1;
      ill_m = 1'b0;
      // No leftover ALUWB: a fresh instruction trace starts right away
      run_instr(7'b0010011, 2, "reset_release");
   endtask

   task automatic test_rtype();
      run_instr(7'b0110011, 0, "rtype");
      run_instr(7'b0010011, 1, "itype");
   endtask

   task automatic test_load_store();
      run_instr(7'b0000011, 2, "load");
      run_instr(7'b0100011, 2, "store");
   endtask

   task automatic test_branch();
      run_instr(7'b1100011, 1, "beq_taken");
      run_instr(7'b1100011, 0, "beq_not_taken");
      run_instr(7'b1101111, 2, "jal");
   endtask

   task automatic test_illegal();
      run_instr(7'b1111111, 2, "illegal");
      run_instr(7'b0110011, 2, "illegal_sticky");
      run_instr(7'b0000000, 2, "illegal_again");
      run_instr(7'b0100011, 2, "illegal_sticky2");
   endtask

   task automatic test_random();
      logic [6:0] legal [6];
      logic [6:0] opc;
      legal = '{7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011, 7'b1100011, 7'b1101111};
      for (int n = 0; n < 150; n++) begin
         if ($urandom_range(0, 9) == 0) opc = 7'($urandom);
         else opc = legal[$urandom_range(0, 5)];
         run_instr(opc, 2, "random");
      end
   endtask

`ifdef CONTROL_MEM_STALL_EN
   task automatic test_stall();
      opcode = 7'b0110011;
      zero = 1'b0;
      mem_ready = 1'b0;
      for (int c = 0; c < 4; c++) begin
         if (c == 3) mem_ready = 1'b1;
         #1;
         vectors++;
         if (state !== 4'(S_FETCH) || ir_write !== 1'b1 || pc_write !== 1'b1) begin
            errors++;
            $display("FAIL stall_fetch cycle %0d: state %0d ir %b pcw %b want state %0d ir 1 pcw 1",
                     c, state, ir_write, pc_write, 4'(S_FETCH));
         end
         @(negedge clk);
      end
      #1;
      vectors++;
      if (state !== 4'(S_DECODE)) begin
         errors++;
         $display("FAIL stall_release: state %0d want %0d", state, 4'(S_DECODE));
      end
      repeat (3) @(negedge clk);
      run_instr(7'b0000011, 2, "after_stall");
   endtask
`endif

   task automatic test_final_reset();
      reset_n = 1'b0;
      @(negedge clk);
      #1;
      vectors++;
      if (illegal !== 1'b0 || state !== 4'(S_FETCH)) begin
         errors++;
         $display("FAIL final_reset: illegal %b state %0d want 0 %0d", illegal, state, 4'(S_FETCH));
      end
   endtask

   initial begin
      @(negedge clk);
      test_reset();
      test_rtype();
      test_load_store();
      test_branch();
      test_illegal();
      test_random();
`ifdef CONTROL_MEM_STALL_EN
      test_stall();
`endif
      test_final_reset();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule
